uart_tx_shifter: RTL and testbench

UART transmit serializer sitting directly downstream of the frame builder. On a send request it raises `tx_active` so the frame builder drives its 11-bit frame. It captures that frame and shifts it out LSB-first on `tx_out`, one bit per baud tick. When the frame is complete it pulses `tx_done`.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_tx_shifter.sv | 89 ++++++++
 tb/tb_uart_tx_shifter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit serializer.
// Holds the FSM state enum, parity codes, frame width and frame-length helper.
package uart_pkg;

    localparam int FRAME_W = 11;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    // Number of line bits to shift for a given configuration.
    // Only the two parity-free legal shapes (7-bit + 2 stop,
    // 8-bit + 1 stop) are 10 bits; every other combination,
    // including the illegal ones, is treated as a full 11-bit
    // frame so tx_done still pulses.
    function automatic logic [3:0] frame_len(
        input logic [1:0] parity_type,
        input logic       data_length,
        input logic       stop_bits
    );
        logic w_has_par;
        w_has_par = (parity_type == PAR_ODD) ||
                    (parity_type == PAR_EVEN);
        if (!w_has_par && (data_length != stop_bits))
            return 4'd10;
        return 4'd11;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// UART transmit serializer: loads an 11-bit frame and shifts it out LSB-first.
// Ports: clk, rst (async low), baud_tick, send, frame_in[10:0], parity_type[1:0],
//        data_length, stop_bits -> tx_out, tx_active, busy, tx_done (all registered).
module uart_tx_shifter
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               baud_tick,
    input  logic               send,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [1:0]         parity_type,
    input  logic               data_length,
    input  logic               stop_bits,
    output logic               tx_out,
    output logic               tx_active,
    output logic               busy,
    output logic               tx_done
);

    state_t             r_state;
    state_t             w_next;
    logic [FRAME_W-1:0] r_sr;
    logic [3:0]         r_bit_cnt;
    logic               w_shift;

    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (send)
                    w_next = LOAD;
            end
            LOAD: begin
                w_next = SHIFT;
            end
            SHIFT: begin
                if (baud_tick) begin
                    // The tick after the last bit closes that
                    // bit's full period before leaving.
                    if (r_bit_cnt == 4'd0)
                        w_next = DONE;
                    else
                        w_shift = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_sr      <= '1;
            r_bit_cnt <= 4'd0;
            tx_out    <= 1'b1;
            tx_active <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            r_state   <= w_next;
            busy      <= (w_next != IDLE);
            tx_active <= (w_next == LOAD) || (w_next == SHIFT);
            tx_done   <= (w_next == DONE);

            if (r_state == LOAD) begin
                r_sr      <= frame_in;
                r_bit_cnt <= frame_len(parity_type,
                                       data_length,
                                       stop_bits);
            end

            if (w_shift) begin
                tx_out    <= r_sr[0];
                r_sr      <= {1'b1, r_sr[FRAME_W-1:1]};
                r_bit_cnt <= r_bit_cnt - 4'd1;
            end else if (w_next != SHIFT) begin
                tx_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Scoreboard bench for uart_tx_shifter: stimulus queues expected line bits,
// a monitor pops and compares on every baud tick and every tx_done.
module tb_uart_tx_shifter;

    logic        clk;
    logic        rst;
    logic        baud_tick;
    logic        send;
    logic [10:0] frame_in;
    logic [1:0]  parity_type;
    logic        data_length;
    logic        stop_bits;
    logic        tx_out;
    logic        tx_active;
    logic        busy;
    logic        tx_done;

    uart_tx_shifter dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .send        (send),
        .frame_in    (frame_in),
        .parity_type (parity_type),
        .data_length (data_length),
        .stop_bits   (stop_bits),
        .tx_out      (tx_out),
        .tx_active   (tx_active),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic is_done;
        logic val;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- monitor ----------------
    logic r_tick_prev = 1'b0;
    logic r_prev_out  = 1'b1;

    always @(posedge clk) r_tick_prev <= baud_tick;

    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            r_prev_out = tx_out;
        end else begin
            if (tx_done) begin
                chk("done_queued", q.size() > 0, 1);
                if (q.size() > 0) begin
                    it = q.pop_front();
                    chk("done_slot", it.is_done, 1);
                    chk("done_on_tick", r_tick_prev, 1);
                    chk("done_line", tx_out, 1);
                    chk("done_active", tx_active, 0);
                end
            end else if (r_tick_prev && busy) begin
                chk("bit_queued", q.size() > 0, 1);
                if (q.size() > 0) begin
                    it = q.pop_front();
                    chk("bit_slot", it.is_done, 0);
                    chk("bit", tx_out, it.val);
                end
            end
            if (!r_tick_prev)
                chk("no_glitch", tx_out, r_prev_out);
            r_prev_out = tx_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        repeat (15) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic push_bits(input logic [0:10] seq, input int n,
                             input int upto, input bit done);
        for (int i = 0; i < n; i++)
            if (i < upto) q.push_back('{1'b0, seq[i]});
        if (done) q.push_back('{1'b1, 1'b1});
    endtask

    // seq is the required line pattern in transmit order.
    task automatic run_frame(input logic [1:0]  pt,
                             input logic        dl,
                             input logic        sb,
                             input logic [10:0] fr,
                             input logic [0:10] seq,
                             input int          n,
                             input int          resend_at,
                             input int          abort_at,
                             input bit          load_tick);
        parity_type = pt;
        data_length = dl;
        stop_bits   = sb;
        frame_in    = fr;
        if (load_tick) q.push_back('{1'b0, 1'b1});
        if (abort_at > 0) push_bits(seq, n, abort_at, 1'b0);
        else              push_bits(seq, n, n, 1'b1);
        send = 1'b1;
        @(negedge clk);
        send      = 1'b0;
        baud_tick = load_tick;
        @(negedge clk);
        baud_tick = 1'b0;
        // stale config must not matter once loaded
        parity_type = ~pt;
        frame_in    = ~fr;
        for (int t = 1; t <= n + 1; t++) begin
            tick();
            if (t == abort_at) begin
                @(negedge clk);
                #3 rst = 1'b0;
                #1;
                chk("rst_tx_out", tx_out, 1);
                chk("rst_active", tx_active, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", tx_done, 0);
                repeat (4) @(negedge clk);
                #2 rst = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            if (t == resend_at) begin
                @(negedge clk);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    // send held high across two frames; second frame_in set after first LOAD
    task automatic run_back2back();
        parity_type = 2'b00;
        data_length = 1'b1;
        stop_bits   = 1'b0;
        frame_in    = 11'b11_10100101_0;
        push_bits(11'b0101001011_1, 10, 10, 1'b1);
        push_bits(11'b0001111001_1, 10, 10, 1'b1);
        send = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_in = 11'b11_00111100_0;
        for (int t = 1; t <= 11; t++) tick();
        repeat (3) @(negedge clk);
        send = 1'b0;
        frame_in = 11'h000;
        for (int t = 1; t <= 11; t++) tick();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        baud_tick   = 1'b0;
        send        = 1'b0;
        frame_in    = '1;
        parity_type = 2'b00;
        data_length = 1'b1;
        stop_bits   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx_out", tx_out, 1);
        chk("reset_active", tx_active, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", tx_done, 0);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 0xA5
        run_frame(2'b00, 1'b1, 1'b0, 11'b11_10100101_0,
                  11'b0101001011_1, 10, -1, -1, 1'b0);
        // 7E2 0x41
        run_frame(2'b10, 1'b0, 1'b1, 11'b11_0_1000001_0,
                  11'b01000001011, 11, -1, -1, 1'b0);
        // send pulsed again during bit 4
        run_frame(2'b00, 1'b1, 1'b0, 11'b11_10100101_0,
                  11'b0101001011_1, 10, 5, -1, 1'b0);
        // back-to-back with send held
        run_back2back();
        // reset during bit 5, then a full frame
        run_frame(2'b00, 1'b1, 1'b0, 11'b11_10100101_0,
                  11'b0101001011_1, 10, -1, 6, 1'b0);
        run_frame(2'b10, 1'b0, 1'b1, 11'b11_0_1000001_0,
                  11'b01000001011, 11, -1, -1, 1'b0);
        // illegal config, all ones
        run_frame(2'b01, 1'b1, 1'b1, 11'h7FF,
                  11'h7FF, 11, -1, -1, 1'b0);
        // tick in LOAD ignored, parity code 11, 0x3C
        run_frame(2'b11, 1'b1, 1'b0, 11'b11_00111100_0,
                  11'b0001111001_1, 10, -1, -1, 1'b1);

        repeat (20) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
